lcd_init_sequencer: RTL

- Controller for the SPI display path between the Ibex demo system's SPI host and the LCD control lines (reset, DC, CS, backlight).
- On a start pulse it runs a command ROM: hardware reset pulse, command/data bytes and timed delays. It then hands SPI ownership back to the CPU.
- Also arbitrates the SPI host byte stream: CPU traffic passes through only while the sequencer is not busy.

---
 rtl/lcd_init_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_init_sequencer.sv
// LCD init sequencer and SPI byte-stream arbiter.
//
// On start_i the sequencer pulses the LCD hardware reset, waits, then walks a
// command ROM of cmd/data bytes and timed delays, and finally hands the SPI
// host back to the CPU. While idle or done, the CPU byte stream and the DC/CS
// request lines pass straight through to the SPI host and the LCD.
//
// Ports:
//   clk_sys_i, rst_sys_i        system clock, asynchronous active-high reset
//   start_i                     single-cycle start pulse
//   busy_o, done_o              sequence running / completed (sticky)
//   rom_addr_o, rom_data_i      command ROM, combinational read
//                               (entry [9:8] type: 00 cmd, 01 data, 10 delay, 11 end)
//   cpu_tx_*, cpu_dc_i, cpu_cs_ni  CPU byte stream and requested DC/CS levels
//   spi_tx_*, spi_idle_i        SPI host byte stream and idle status
//   lcd_rst_no, lcd_dc_o, lcd_cs_no, lcd_bl_o  LCD control lines
module lcd_init_sequencer #(
    parameter int unsigned AddrWidth       = 5,
    parameter int unsigned ResetCycles     = 16,
    parameter int unsigned DelayUnitCycles = 50000
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AddrWidth-1:0] rom_addr_o,
    input  logic [9:0]           rom_data_i,
    input  logic                 cpu_tx_valid_i,
    input  logic [7:0]           cpu_tx_data_i,
    output logic                 cpu_tx_ready_o,
    input  logic                 cpu_dc_i,
    input  logic                 cpu_cs_ni,
    output logic                 spi_tx_valid_o,
    output logic [7:0]           spi_tx_data_o,
    input  logic                 spi_tx_ready_i,
    input  logic                 spi_idle_i,
    output logic                 lcd_rst_no,
    output logic                 lcd_dc_o,
    output logic                 lcd_cs_no,
    output logic                 lcd_bl_o
);

    localparam int unsigned DelayMax = 255 * DelayUnitCycles;
    localparam int unsigned CntMax   = (DelayMax > ResetCycles) ? DelayMax : ResetCycles;
    localparam int unsigned CntWidth = $clog2(CntMax + 1);

    localparam logic [CntWidth-1:0]  RstLast  = CntWidth'(ResetCycles - 1);
    localparam logic [AddrWidth-1:0] AddrLast = '1;

    localparam logic [1:0] TypeCmd   = 2'b00;
    localparam logic [1:0] TypeData  = 2'b01;
    localparam logic [1:0] TypeDelay = 2'b10;

    typedef enum logic [3:0] {
        StIdle, StRstLo, StRstWait, StFetch, StSend, StDrain, StDelay, StFinish, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [7:0]            payload_q, payload_d;
    logic                  target_dc_q, target_dc_d;
    logic                  valid_q, valid_d;
    logic                  dc_q, dc_d;
    logic                  cs_n_q, cs_n_d;
    logic                  rst_n_q, rst_n_d;
    logic                  bl_q, bl_d;
    logic                  done_q, done_d;

    logic                  granted;
    logic                  cpu_hs;
    logic [CntWidth-1:0]   delay_cycles;
    logic                  delay_done;

    assign granted      = (state_q == StIdle) || (state_q == StDone);
    assign cpu_hs       = cpu_tx_valid_i & spi_tx_ready_i;
    assign delay_cycles = CntWidth'(payload_q) * CntWidth'(DelayUnitCycles);
    // A zero-length delay still spends one cycle in StDelay.
    assign delay_done   = (cnt_q + CntWidth'(1)) >= delay_cycles;

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            payload_q   <= '0;
            target_dc_q <= 1'b0;
            valid_q     <= 1'b0;
            dc_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            rst_n_q     <= 1'b1;
            bl_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            payload_q   <= payload_d;
            target_dc_q <= target_dc_d;
            valid_q     <= valid_d;
            dc_q        <= dc_d;
            cs_n_q      <= cs_n_d;
            rst_n_q     <= rst_n_d;
            bl_q        <= bl_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        payload_d   = payload_q;
        target_dc_d = target_dc_q;
        valid_d     = valid_q;
        dc_d        = dc_q;
        cs_n_d      = cs_n_q;
        rst_n_d     = rst_n_q;
        bl_d        = bl_q;
        done_d      = done_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StRstLo;
                    cnt_d   = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    bl_d    = 1'b0;
                    dc_d    = 1'b0;
                    cs_n_d  = 1'b1;
                    valid_d = 1'b0;
                    // A CPU byte accepted on this edge must finish shifting
                    // before the LCD is reset, so hold reset off until idle.
                    rst_n_d = cpu_hs;
                end
            end
            StRstLo: begin
                if (!rst_n_q) begin
                    if (cnt_q == RstLast) begin
                        rst_n_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StRstWait;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end else if (spi_idle_i) begin
                    rst_n_d = 1'b0;
                end
            end
            StRstWait: begin
                if (cnt_q == RstLast) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    state_d = StFetch;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StFetch: begin
                payload_d   = rom_data_i[7:0];
                target_dc_d = rom_data_i[8];
                cnt_d       = '0;
                case (rom_data_i[9:8])
                    TypeCmd, TypeData: begin
                        if (rom_data_i[8] == dc_q) begin
                            state_d = StSend;
                            valid_d = 1'b1;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                    TypeDelay: state_d = StDelay;
                    default:   state_d = StFinish;
                endcase
            end
            StDrain: begin
                // DC moves on the first idle cycle; valid follows a cycle later.
                if (spi_idle_i) begin
                    if (dc_q == target_dc_q) begin
                        state_d = StSend;
                        valid_d = 1'b1;
                    end else begin
                        dc_d = target_dc_q;
                    end
                end
            end
            StSend: begin
                if (spi_tx_ready_i) begin
                    valid_d = 1'b0;
                    if (addr_q == AddrLast) begin
                        state_d = StFinish;
                    end else begin
                        addr_d  = addr_q + AddrWidth'(1);
                        state_d = StFetch;
                    end
                end
            end
            StDelay: begin
                if (delay_done) begin
                    if (addr_q == AddrLast) begin
                        state_d = StFinish;
                    end else begin
                        addr_d  = addr_q + AddrWidth'(1);
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StFinish: begin
                if (spi_idle_i) begin
                    cs_n_d  = 1'b1;
                    bl_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o         = !granted;
    assign done_o         = done_q;
    assign rom_addr_o     = addr_q;
    assign cpu_tx_ready_o = granted & spi_tx_ready_i;
    assign spi_tx_valid_o = granted ? cpu_tx_valid_i : valid_q;
    assign spi_tx_data_o  = granted ? cpu_tx_data_i : payload_q;
    assign lcd_dc_o       = granted ? cpu_dc_i : dc_q;
    assign lcd_cs_no      = granted ? cpu_cs_ni : cs_n_q;
    assign lcd_rst_no     = rst_n_q;
    assign lcd_bl_o       = bl_q;

endmodule
